// File: rtl/float_multiplier_param.sv
// Multi-cycle FP multiplier (EXP_W/MAN_W), subnormals flushed, Inf/NaN handled, FMUL_ROUND_RNE_EN selects RNE else truncate.
// Latency: out_valid 4 cycles after accept; one result per 5 cycles.
// Backpressure: result and flags held while out_valid && !out_ready; in_ready only in IDLE.
module float_multiplier_param #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 7
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   y,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int PW   = 2 * (MAN_W + 1);
   localparam int XW   = EXP_W + 2;
   localparam int BIAS = 2**(EXP_W-1) - 1;
   localparam logic [EXP_W-1:0]        EXP_ONES = '1;
   localparam logic signed [XW-1:0]    EXP_MAX  = XW'(2**EXP_W - 1);
   localparam logic signed [XW-1:0]    BIAS_X   = XW'(BIAS);

   typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;

   state_t state, state_nxt;

   logic [W-1:0]            a_q, b_q;
   logic                    sign_q;
   logic                    is_nan_q, is_inf_q, is_zero_q;
   logic [PW-1:0]           prod_q;
   logic signed [XW-1:0]    exp_q;
   logic [MAN_W:0]          man_q;
   logic                    g_q, s_q;

   // ---------------- operand decode (MUL stage) ----------------
   logic [EXP_W-1:0]        ea, eb;
   logic [MAN_W-1:0]        fa, fb;
   logic                    a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
   logic [PW-1:0]           mul_prod;
   logic signed [XW-1:0]    mul_exp;

   assign ea = a_q[W-2 -: EXP_W];
   assign eb = b_q[W-2 -: EXP_W];
   assign fa = a_q[MAN_W-1:0];
   assign fb = b_q[MAN_W-1:0];

   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (ea == EXP_ONES) && (fa == '0);
   assign b_inf  = (eb == EXP_ONES) && (fb == '0);
   assign a_nan  = (ea == EXP_ONES) && (fa != '0);
   assign b_nan  = (eb == EXP_ONES) && (fb != '0);

   assign mul_prod = PW'({1'b1, fa}) * PW'({1'b1, fb});
   assign mul_exp  = $signed(XW'(ea)) + $signed(XW'(eb)) - BIAS_X;

   // ---------------- normalise (NORM stage) ----------------
   logic [PW-1:0]           norm_vec;
   logic [MAN_W:0]          norm_man;
   logic                    norm_g, norm_s;
   logic signed [XW-1:0]    norm_exp;

   // Left-align so the leading one sits in the MSB; a right shift then
   // becomes "take the top bits", and the dropped LSB lands in sticky.
   assign norm_vec = prod_q[PW-1] ? prod_q : {prod_q[PW-2:0], 1'b0};
   assign norm_man = norm_vec[PW-1 -: MAN_W+1];
   assign norm_g   = norm_vec[MAN_W];
   assign norm_s   = |norm_vec[MAN_W-1:0];
   assign norm_exp = exp_q + $signed({{(XW-1){1'b0}}, prod_q[PW-1]});

   // ---------------- round (ROUND stage) ----------------
   logic [MAN_W:0]          rnd_man;
   logic signed [XW-1:0]    rnd_exp;
   logic                    unused_ok;

`ifdef FMUL_ROUND_RNE_EN
   logic                    rnd_inc;
   logic [MAN_W+1:0]        rnd_sum;

   assign rnd_inc = g_q & (s_q | man_q[0]);
   assign rnd_sum = {1'b0, man_q} + {{(MAN_W+1){1'b0}}, rnd_inc};
   assign rnd_man = rnd_sum[MAN_W+1] ? rnd_sum[MAN_W+1:1] : rnd_sum[MAN_W:0];
   assign rnd_exp = exp_q + $signed({{(XW-1){1'b0}}, rnd_sum[MAN_W+1]});
   assign unused_ok = rnd_man[MAN_W];
`else
   assign rnd_man   = man_q;
   assign rnd_exp   = exp_q;
   assign unused_ok = ^{rnd_man[MAN_W], g_q, s_q};
`endif

   logic [W-1:0]            fin_y;
   logic                    fin_ovf, fin_unf;

   always_comb begin
      fin_y   = '0;
      fin_ovf = 1'b0;
      fin_unf = 1'b0;
      if (is_nan_q) begin
         fin_y = {sign_q, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      end else if (is_inf_q) begin
         fin_y = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      end else if (is_zero_q) begin
         fin_y = {sign_q, {(W-1){1'b0}}};
      end else if (rnd_exp >= EXP_MAX) begin
         fin_y   = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
         fin_ovf = 1'b1;
      end else if (rnd_exp <= $signed(XW'(0))) begin
         fin_y   = {sign_q, {(W-1){1'b0}}};
         fin_unf = 1'b1;
      end else begin
         fin_y = {sign_q, rnd_exp[EXP_W-1:0], rnd_man[MAN_W-1:0]};
      end
   end

   // ---------------- control ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = MUL;
         MUL:     state_nxt = NORM;
         NORM:    state_nxt = ROUND;
         ROUND:   state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE) && !reset;
   assign out_valid = (state == DONE);

   // ---------------- datapath registers ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_q       <= '0;
         b_q       <= '0;
         sign_q    <= 1'b0;
         is_nan_q  <= 1'b0;
         is_inf_q  <= 1'b0;
         is_zero_q <= 1'b0;
         prod_q    <= '0;
         exp_q     <= '0;
         man_q     <= '0;
         g_q       <= 1'b0;
         s_q       <= 1'b0;
         y         <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q <= a;
                  b_q <= b;
               end
            end
            MUL: begin
               prod_q    <= mul_prod;
               exp_q     <= mul_exp;
               sign_q    <= a_q[W-1] ^ b_q[W-1];
               is_nan_q  <= a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
               is_inf_q  <= a_inf | b_inf;
               is_zero_q <= a_zero | b_zero;
            end
            NORM: begin
               man_q <= norm_man;
               g_q   <= norm_g;
               s_q   <= norm_s;
               exp_q <= norm_exp;
            end
            ROUND: begin
               y         <= fin_y;
               overflow  <= fin_ovf;
               underflow <= fin_unf;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_float_multiplier_param.sv
// Bench for float_multiplier_param: BF16 and E4M3 instances run in lockstep,
// table vectors, handshake/reset sequences and random operands against a value-level model.
module tb_float_multiplier_param;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic        in_valid, out_ready;
   logic [15:0] bf_a, bf_b, bf_y;
   logic        bf_in_ready, bf_out_valid, bf_ovf, bf_unf;
   logic [7:0]  e4_a, e4_b, e4_y;
   logic        e4_in_ready, e4_out_valid, e4_ovf, e4_unf;

   float_multiplier_param #(.EXP_W(8), .MAN_W(7)) u_bf16 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(bf_in_ready),
      .a(bf_a), .b(bf_b), .out_valid(bf_out_valid), .out_ready(out_ready),
      .y(bf_y), .overflow(bf_ovf), .underflow(bf_unf));

   float_multiplier_param #(.EXP_W(4), .MAN_W(3)) u_e4m3 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(e4_in_ready),
      .a(e4_a), .b(e4_b), .out_valid(e4_out_valid), .out_ready(out_ready),
      .y(e4_y), .overflow(e4_ovf), .underflow(e4_unf));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

`ifdef FMUL_ROUND_RNE_EN
   localparam logic [15:0] TIE_Y = 16'h3FC2;
`else
   localparam logic [15:0] TIE_Y = 16'h3FC1;
`endif

   // Value-level model: exact integer product, rounded to MAN_W+1 significant bits.
   function automatic void ref_mul(input int ew, input int mw, input longint av, input longint bv,
                                   output longint ry, output bit rovf, output bit runf);
      longint emax, bias, mmask, s, ea, eb, fa, fb, p, q, r, half, e, be;
      int l, k;
      bit na, nb, ia, ib, za, zb;
      emax  = (longint'(1) << ew) - 1;
      bias  = (longint'(1) << (ew - 1)) - 1;
      mmask = (longint'(1) << mw) - 1;
      s  = ((av >> (ew + mw)) ^ (bv >> (ew + mw))) & 1;
      ea = (av >> mw) & emax;   eb = (bv >> mw) & emax;
      fa = av & mmask;          fb = bv & mmask;
      na = (ea == emax) && (fa != 0);  nb = (eb == emax) && (fb != 0);
      ia = (ea == emax) && (fa == 0);  ib = (eb == emax) && (fb == 0);
      za = (ea == 0);                  zb = (eb == 0);
      rovf = 1'b0;
      runf = 1'b0;
      if (na || nb || (za && ib) || (ia && zb))
         ry = (s << (ew + mw)) | (emax << mw) | (longint'(1) << (mw - 1));
      else if (ia || ib)
         ry = (s << (ew + mw)) | (emax << mw);
      else if (za || zb)
         ry = s << (ew + mw);
      else begin
         p = (fa | (longint'(1) << mw)) * (fb | (longint'(1) << mw));
         l = (p >= (longint'(1) << (2 * mw + 1))) ? 2 * mw + 1 : 2 * mw;
         k = l - mw;
         q = p >> k;
         r = p & ((longint'(1) << k) - 1);
         half = longint'(1) << (k - 1);
         e = ea + eb - 2 * bias + (l - 2 * mw);
`ifdef FMUL_ROUND_RNE_EN
         if (r > half || (r == half && (q & 1) == 1)) q = q + 1;
`endif
         if (q == (longint'(1) << (mw + 1))) begin
            q = q >> 1;
            e = e + 1;
         end
         be = e + bias;
         if (be >= emax) begin
            ry = (s << (ew + mw)) | (emax << mw);
            rovf = 1'b1;
         end else if (be <= 0) begin
            ry = s << (ew + mw);
            runf = 1'b1;
         end else
            ry = (s << (ew + mw)) | (be << mw) | (q & mmask);
      end
   endfunction

   // One transaction on both DUTs; returns when out_valid is seen (edges after accept in lat).
   task automatic op(input logic [15:0] ba, input logic [15:0] bb,
                     input logic [7:0] xa, input logic [7:0] xb,
                     output logic [15:0] ybf, output logic [1:0] fbf,
                     output logic [7:0] ye4, output logic [1:0] fe4);
      int w;
      int lat;
      w = 0;
      while (!(bf_in_ready && e4_in_ready) && w < 20) begin
         @(posedge clock); #1; w++;
      end
      check("in_ready_wait", {31'd0, bf_in_ready & e4_in_ready}, 32'd1);
      bf_a = ba; bf_b = bb; e4_a = xa; e4_b = xb;
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      bf_a = 16'($urandom); bf_b = 16'($urandom);
      e4_a = 8'($urandom);  e4_b = 8'($urandom);
      lat = 0;
      while (!(bf_out_valid && e4_out_valid) && lat < 20) begin
         @(posedge clock); #1; lat++;
      end
      // out_valid registered on the 3rd edge after accept, seen by the consumer on the 4th.
      check("latency", 32'(lat), 32'd3);
      ybf = bf_y; fbf = {bf_ovf, bf_unf};
      ye4 = e4_y; fe4 = {e4_ovf, e4_unf};
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] y;
      logic        ovf;
      logic        unf;
   } vec_t;

   function automatic logic [15:0] rand_bf();
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(0, 9) < 8) v[14:7] = 8'($urandom_range(96, 158));
      return v;
   endfunction

   initial begin
      vec_t        tbl[14];
      logic [15:0] ybf;
      logic [7:0]  ye4;
      logic [1:0]  fbf, fe4;
      longint      ry;
      bit          rovf, runf;
      logic [15:0] ra, rb;
      logic [7:0]  xa, xb;
      int          bad;

      tbl[0]  = '{16'h3FC0, 16'h3FC0, 16'h4010, 1'b0, 1'b0};
      tbl[1]  = '{16'h3FC0, 16'h3F81, TIE_Y,    1'b0, 1'b0};
      tbl[2]  = '{16'h7F00, 16'h7F00, 16'h7F80, 1'b1, 1'b0};
      tbl[3]  = '{16'h0080, 16'h0080, 16'h0000, 1'b0, 1'b1};
      tbl[4]  = '{16'h0000, 16'hBF80, 16'h8000, 1'b0, 1'b0};
      tbl[5]  = '{16'h7F80, 16'h0000, 16'h7FC0, 1'b0, 1'b0};
      tbl[6]  = '{16'hFF80, 16'h3F80, 16'hFF80, 1'b0, 1'b0};
      tbl[7]  = '{16'h7FC1, 16'h3F80, 16'h7FC0, 1'b0, 1'b0};
      tbl[8]  = '{16'hFFC0, 16'h3F80, 16'hFFC0, 1'b0, 1'b0};
      tbl[9]  = '{16'hFF80, 16'hFF80, 16'h7F80, 1'b0, 1'b0};
      tbl[10] = '{16'h7F00, 16'h3F80, 16'h7F00, 1'b0, 1'b0};
      tbl[11] = '{16'h7F00, 16'h4000, 16'h7F80, 1'b1, 1'b0};
      tbl[12] = '{16'h0080, 16'h3F80, 16'h0080, 1'b0, 1'b0};
      tbl[13] = '{16'h0080, 16'h3F00, 16'h0000, 1'b0, 1'b1};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      bf_a = '0; bf_b = '0; e4_a = '0; e4_b = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_in_ready",  {31'd0, bf_in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, bf_out_valid}, 32'd0);
      check("rst_y",         {16'd0, bf_y}, 32'd0);
      check("rst_flags",     {30'd0, bf_ovf, bf_unf}, 32'd0);
      reset = 1'b0;
      #1;
      check("idle_in_ready", {31'd0, bf_in_ready}, 32'd1);

      foreach (tbl[i]) begin
         op(tbl[i].a, tbl[i].b, 8'h3C, 8'h40, ybf, fbf, ye4, fe4);
         check($sformatf("vec%0d_y", i), {16'd0, ybf}, {16'd0, tbl[i].y});
         check($sformatf("vec%0d_flags", i), {30'd0, fbf}, {30'd0, tbl[i].ovf, tbl[i].unf});
         check($sformatf("vec%0d_e4m3_y", i), {24'd0, ye4}, 32'h44);
      end

      // Throughput: DONE leaves on the edge after out_valid is seen; IDLE next.
      op(16'h3FC0, 16'h3FC0, 8'h3C, 8'h40, ybf, fbf, ye4, fe4);
      @(posedge clock); #1;
      check("thru_in_ready", {31'd0, bf_in_ready}, 32'd1);
      check("thru_out_valid", {31'd0, bf_out_valid}, 32'd0);

      // Backpressure: hold out_ready low six cycles.
      out_ready = 1'b0;
      op(16'h3FC0, 16'h3FC0, 8'h3C, 8'h40, ybf, fbf, ye4, fe4);
      bad = 0;
      repeat (6) begin
         @(posedge clock); #1;
         if (bf_y !== 16'h4010 || bf_out_valid !== 1'b1 || bf_in_ready !== 1'b0 ||
             bf_ovf !== 1'b0 || bf_unf !== 1'b0) bad++;
      end
      check("bp_hold_errors", 32'(bad), 32'd0);
      check("bp_y", {16'd0, bf_y}, 32'h4010);
      out_ready = 1'b1;
      @(posedge clock); #1;
      check("bp_release_valid", {31'd0, bf_out_valid}, 32'd0);

      // Reset while in NORM: nothing may emerge, next op is clean.
      bf_a = 16'h7F00; bf_b = 16'h7F00; e4_a = 8'h3C; e4_b = 8'h40;
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      check("busy_in_ready", {31'd0, bf_in_ready}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      check("midrst_out_valid", {31'd0, bf_out_valid}, 32'd0);
      check("midrst_in_ready", {31'd0, bf_in_ready}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      bad = 0;
      repeat (6) begin
         @(posedge clock); #1;
         if (bf_out_valid !== 1'b0 || e4_out_valid !== 1'b0) bad++;
      end
      check("midrst_no_output", 32'(bad), 32'd0);
      check("midrst_flags", {30'd0, bf_ovf, bf_unf}, 32'd0);
      op(16'h3FC0, 16'h3F81, 8'h3C, 8'h40, ybf, fbf, ye4, fe4);
      check("post_rst_y", {16'd0, ybf}, {16'd0, TIE_Y});
      check("post_rst_e4_y", {24'd0, ye4}, 32'h44);

      // Random operands against the model.
      for (int n = 0; n < 150; n++) begin
         ra = rand_bf(); rb = rand_bf();
         xa = 8'($urandom); xb = 8'($urandom);
         op(ra, rb, xa, xb, ybf, fbf, ye4, fe4);
         ref_mul(8, 7, longint'(ra), longint'(rb), ry, rovf, runf);
         check($sformatf("rnd_bf_%h_%h", ra, rb), {14'd0, fbf, ybf}, {14'd0, rovf, runf, 16'(ry)});
         ref_mul(4, 3, longint'(xa), longint'(xb), ry, rovf, runf);
         check($sformatf("rnd_e4_%h_%h", xa, xb), {22'd0, fe4, ye4}, {22'd0, rovf, runf, 8'(ry)});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/float_multiplier_param.md
# float_multiplier_param

Parametrised, multi-cycle floating-point multiplier for the small-float datapath. It covers E4M3, BF16 and any IEEE-style format through exponent and mantissa width parameters. Operands are accepted on a valid/ready handshake and the product is held on a valid/ready output. The block adds rounding, overflow and underflow detection, and Inf/NaN handling to the existing fixed-format multipliers.

## Interface
- `EXP_W`, 8, exponent field width (≥3)
- `MAN_W`, 7, stored mantissa width, hidden bit excluded (≥2)
- `BIAS`, `2**(EXP_W-1)-1`, exponent bias (derived, not overridden)
- `clock`  input  1  single clock, rising edge
- `reset`  input  1  asynchronous, active-high
- `in_valid`  input  1  operands present
- `in_ready`  output  1  block can accept operands
- `a`, `b`  input  `1+EXP_W+MAN_W`  operands {sign, exp, man}
- `out_valid`  output  1  result present
- `out_ready`  input  1  consumer takes result
- `y`  output  `1+EXP_W+MAN_W`  product
- `overflow`  output  1  result saturated to Inf; valid with `out_valid`
- `underflow`  output  1  result flushed to zero; valid with `out_valid`

## Operation
- FSM states and transitions:
  - `IDLE`: `in_ready` is 1. On `in_valid && in_ready`, register `a`/`b` and go to `MUL`.
  - `MUL`: form the `2*(MAN_W+1)`-bit product of the hidden-bit mantissas. Form the exponent sum `ea+eb-BIAS` in `EXP_W+2` signed bits. Classify operands. Go to `NORM`.
  - `NORM`: if product MSB is set, shift right 1 and add 1 to the exponent. Keep `MAN_W+1` bits, plus guard bit G and sticky bit S (OR of all lower bits). Go to `ROUND`.
  - `ROUND`: apply rounding (see Configuration). If the mantissa carries out, shift right 1 and add 1 to the exponent. Check range, register `y` and flags, go to `DONE`.
  - `DONE`: `out_valid` is 1. On `out_ready`, go to `IDLE`.
- Operand classes:
  - Exp field 0 is zero; subnormals are flushed to zero.
  - Exp all-ones with man 0 is Inf.
  - Exp all-ones with man ≠0 is NaN.
- Result sign is always `a[MSB]^b[MSB]`, including for zero, Inf and NaN results.
- Special results, in priority order:
  - NaN operand, or zero×Inf: canonical NaN (exp all-ones, man MSB 1, rest 0). Flags 0.
  - Inf operand: Inf. `overflow` is 0.
  - Zero operand: signed zero. `underflow` is 0.
- Range checks, applied after rounding:
  - Biased exponent ≥ all-ones: Inf, `overflow` is 1.
  - Biased exponent ≤ 0: signed zero, `underflow` is 1.
- Special cases take the full FSM path, so latency is uniform.

## Timing
- Reset values: `in_ready`=0 while `reset` is high, then 1 in `IDLE`. `out_valid`=0, `y`=0, `overflow`=0, `underflow`=0, state `IDLE`.
- Latency: accept edge at T gives `out_valid` high from T+4.
- Throughput: with `out_ready` held at 1, one result per 5 cycles. `DONE` returns to `IDLE` at T+5 and the next accept edge is T+5.
- `in_ready` is low in every state except `IDLE`. Inputs are ignored outside `IDLE`.
- Backpressure: `y`, `overflow`, `underflow` and `out_valid` hold stable while `out_valid && !out_ready`.
- `out_valid` drops the cycle after the handshake edge.
- `reset` asserted in any state returns to `IDLE` immediately and clears outputs. The in-flight operation is discarded with no partial output.
- `a`/`b` may change after the accept edge without affecting the result.

## Configuration
- Macro: `FMUL_ROUND_RNE_EN`.
- Defined: round to nearest, ties to even. Increment when `G && (S || LSB)`.
- Undefined: truncate toward zero. G and S are ignored and no post-round renormalise occurs.
- Overflow, underflow and special-case behaviour are identical in both builds.

## Test plan
- BF16, `0x3FC0 × 0x3FC0` (1.5×1.5): `y`=`0x4010`, flags 0, `out_valid` at T+4.
- BF16 tie, `0x3FC0 × 0x3F81`: `y`=`0x3FC2` with `FMUL_ROUND_RNE_EN`, `0x3FC1` without.
- BF16, `0x7F00 × 0x7F00`: `y`=`0x7F80`, `overflow`=1. `0x0080 × 0x0080`: `y`=`0x0000`, `underflow`=1.
- BF16 specials:
  - `0x0000 × 0xBF80`: `y`=`0x8000`.
  - `0x7F80 × 0x0000`: `y`=`0x7FC0`.
  - `0xFF80 × 0x3F80`: `y`=`0xFF80`.
- `EXP_W`=4, `MAN_W`=3, `0x3C × 0x40` (1.5×2.0): `y`=`0x44`.
- Handshake: hold `out_ready`=0 for 6 cycles, and check `y` stable and `in_ready`=0. Assert `reset` in `NORM`, and check `out_valid` stays 0 and the next accept yields the correct product.
